gray_fifo_ctrl: RTL and testbench
=================================

Name: gray_fifo_ctrl

Overview:
- Single-clock FIFO pointer/flag controller that sequences write and read pointers for an external dual-port RAM.
- Keeps binary pointers internally and exports registered Gray-coded pointers for status logic and downstream pointer comparators.
- Generates Full, Empty, AlmostFull, fill level and sticky over/underflow errors.
- Sits between the capture datapath (producer) and the readout/USB interface (consumer).

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
AFULL_LEVEL, 12, Level_out value at or above which AlmostFull_out asserts; legal range 1..DEPTH

Ports:
Clk  input  1  clock, all logic on rising edge
Clear_in  input  1  asynchronous active-high reset
Flush_in  input  1  synchronous flush: empties FIFO and clears error flags
WrEn_in  input  1  producer write request
RdEn_in  input  1  consumer read request
WrAck_out  output  1  combinational: write accepted this cycle
RdAck_out  output  1  combinational: read accepted this cycle
WrAddr_out  output  ADDR_WIDTH  RAM write address (low bits of write pointer)
RdAddr_out  output  ADDR_WIDTH  RAM read address (low bits of read pointer)
WrPtrGray_out  output  ADDR_WIDTH+1  registered Gray code of the write pointer
RdPtrGray_out  output  ADDR_WIDTH+1  registered Gray code of the read pointer
Level_out  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH
Full_out  output  1  registered, Level_out == DEPTH
Empty_out  output  1  registered, Level_out == 0
AlmostFull_out  output  1  registered, Level_out >= AFULL_LEVEL
Overflow_out  output  1  sticky: write requested while full
Underflow_out  output  1  sticky: read requested while empty

Behaviour:
- Reset (Clear_in high, asynchronous): both pointers 0, all Gray outputs 0, Level_out 0, Empty_out 1, Full_out 0, AlmostFull_out 0, Overflow_out 0, Underflow_out 0.
- Pointers are ADDR_WIDTH+1 bits binary. The extra MSB distinguishes full from empty. Wrap is modulo 2**(ADDR_WIDTH+1).
- WrAck_out = WrEn_in & ~Full_out & ~Flush_in.
- RdAck_out = RdEn_in & ~Empty_out & ~Flush_in.
- Flags are the registered values from the previous edge. No same-cycle bypass:
  - When full, a simultaneous read and write accepts only the read.
  - When empty, a simultaneous read and write accepts only the write.
- Accepted write: write pointer increments at the next edge. The RAM writes at the current WrAddr_out on that edge.
- Accepted read: read pointer increments at the next edge. RdAddr_out presents the current head; RAM read latency belongs to the consumer.
- Gray outputs equal ptr_next ^ (ptr_next >> 1). They are registered in the same edge as the pointer update, so Gray and binary never disagree. Successive values differ in exactly one bit, including at the 2**(ADDR_WIDTH+1) wrap.
- Level_out, Full_out, Empty_out and AlmostFull_out are computed from the next pointer values and registered on the same edge, so they lag the handshake by 0 cycles relative to the pointers.
- Level arithmetic: wr_next - rd_next, computed in ADDR_WIDTH+1 bits modulo.
- Overflow_out sets on the edge after WrEn_in & Full_out & ~Flush_in. Underflow_out sets on the edge after RdEn_in & Empty_out & ~Flush_in. Both stay set until Clear_in or Flush_in.
- Flush_in has priority over WrEn_in and RdEn_in. On the next edge it forces the reset values on all registered outputs (pointers, Gray outputs, Level_out, flags and both error flags).
- Clear_in asserted mid-operation aborts any in-flight access immediately. No partial pointer update survives.

Test Plan:
- Reset then idle 5 cycles -> Empty_out=1, Full_out=0, Level_out=0, both Gray outputs 0, both Ack outputs 0.
- 16 consecutive writes, no reads -> WrPtrGray_out sequence 1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,24. Level_out=16, Full_out=1. AlmostFull_out rises the edge Level_out reaches 12.
- From full, assert WrEn_in and RdEn_in together for one cycle -> RdAck=1, WrAck=0, Level_out=15, Full_out=0. Then a 17th WrEn_in with the FIFO refilled to 16 -> WrAck=0 and Overflow_out=1, staying set.
- 40 writes interleaved with reads so the pointers pass 31->0 -> each Gray step changes exactly one bit. RdAddr_out wraps 15->0. No flag glitch; Level_out stays consistent.
- Empty FIFO with RdEn_in=1 -> RdAck=0, Underflow_out=1. Simultaneous WrEn and RdEn while empty -> only the write is accepted; Level_out=1, Empty_out=0.
- Level 7 with Overflow_out set, pulse Flush_in with WrEn_in=1 -> next edge Level_out=0, Empty_out=1, errors cleared, WrAck=0. Also assert Clear_in asynchronously mid-burst -> outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller for an external dual-port RAM.
// Binary pointers internally, registered Gray pointers, level and status flags out.
module gray_fifo_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic                  Flush_in,
    input  logic                  WrEn_in,
    input  logic                  RdEn_in,
    output logic                  WrAck_out,
    output logic                  RdAck_out,
    output logic [ADDR_WIDTH-1:0] WrAddr_out,
    output logic [ADDR_WIDTH-1:0] RdAddr_out,
    output logic [ADDR_WIDTH:0]   WrPtrGray_out,
    output logic [ADDR_WIDTH:0]   RdPtrGray_out,
    output logic [ADDR_WIDTH:0]   Level_out,
    output logic                  Full_out,
    output logic                  Empty_out,
    output logic                  AlmostFull_out,
    output logic                  Overflow_out,
    output logic                  Underflow_out
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LEVEL);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_gray_r;
    logic [PW-1:0] rd_gray_r;
    logic [PW-1:0] level_r;
    logic          full_r;
    logic          empty_r;
    logic          afull_r;
    logic          ovf_r;
    logic          unf_r;

    logic          wr_ack_s;
    logic          rd_ack_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [PW-1:0] level_next_s;
    logic          ovf_next_s;
    logic          unf_next_s;

    // Handshake and next-state values; flags are last edge's, no same-cycle bypass.
    always_comb begin
        wr_ack_s      = WrEn_in & ~full_r & ~Flush_in;
        rd_ack_s      = RdEn_in & ~empty_r & ~Flush_in;
        wr_ptr_next_s = wr_ptr_r + {{ADDR_WIDTH{1'b0}}, wr_ack_s};
        rd_ptr_next_s = rd_ptr_r + {{ADDR_WIDTH{1'b0}}, rd_ack_s};
        level_next_s  = wr_ptr_next_s - rd_ptr_next_s;
        ovf_next_s    = ovf_r | (WrEn_in & full_r);
        unf_next_s    = unf_r | (RdEn_in & empty_r);
    end

    // Pointer, Gray, level and flag registers; flush returns everything to reset values.
    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            wr_gray_r <= {PW{1'b0}};
            rd_gray_r <= {PW{1'b0}};
            level_r   <= {PW{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            afull_r   <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else if (Flush_in) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            wr_gray_r <= {PW{1'b0}};
            rd_gray_r <= {PW{1'b0}};
            level_r   <= {PW{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            afull_r   <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            wr_gray_r <= bin2gray(wr_ptr_next_s);
            rd_gray_r <= bin2gray(rd_ptr_next_s);
            level_r   <= level_next_s;
            full_r    <= (level_next_s == DEPTH_C);
            empty_r   <= (level_next_s == {PW{1'b0}});
            afull_r   <= (level_next_s >= AFULL_C);
            ovf_r     <= ovf_next_s;
            unf_r     <= unf_next_s;
        end
    end

    assign WrAck_out      = wr_ack_s;
    assign RdAck_out      = rd_ack_s;
    assign WrAddr_out     = wr_ptr_r[ADDR_WIDTH-1:0];
    assign RdAddr_out     = rd_ptr_r[ADDR_WIDTH-1:0];
    assign WrPtrGray_out  = wr_gray_r;
    assign RdPtrGray_out  = rd_gray_r;
    assign Level_out      = level_r;
    assign Full_out       = full_r;
    assign Empty_out      = empty_r;
    assign AlmostFull_out = afull_r;
    assign Overflow_out   = ovf_r;
    assign Underflow_out  = unf_r;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Randomized self-checking bench for gray_fifo_ctrl against a counter-based FIFO model.
module tb_gray_fifo_ctrl;

    logic       Clk;
    logic       Clear_in;
    logic       Flush_in;
    logic       WrEn_in;
    logic       RdEn_in;
    logic       WrAck_out;
    logic       RdAck_out;
    logic [3:0] WrAddr_out;
    logic [3:0] RdAddr_out;
    logic [4:0] WrPtrGray_out;
    logic [4:0] RdPtrGray_out;
    logic [4:0] Level_out;
    logic       Full_out;
    logic       Empty_out;
    logic       AlmostFull_out;
    logic       Overflow_out;
    logic       Underflow_out;

    gray_fifo_ctrl #(.ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
        .Clk(Clk), .Clear_in(Clear_in), .Flush_in(Flush_in),
        .WrEn_in(WrEn_in), .RdEn_in(RdEn_in),
        .WrAck_out(WrAck_out), .RdAck_out(RdAck_out),
        .WrAddr_out(WrAddr_out), .RdAddr_out(RdAddr_out),
        .WrPtrGray_out(WrPtrGray_out), .RdPtrGray_out(RdPtrGray_out),
        .Level_out(Level_out), .Full_out(Full_out), .Empty_out(Empty_out),
        .AlmostFull_out(AlmostFull_out), .Overflow_out(Overflow_out),
        .Underflow_out(Underflow_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: total accepted writes/reads as plain integers plus sticky errors.
    int m_wr  = 0;
    int m_rd  = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    int gray_tbl [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int exp_gray(input int n);
        int p = n % 32;
        return p ^ (p / 2);
    endfunction

    function automatic int m_level();
        return m_wr - m_rd;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic check_state();
        check_val("level", int'(Level_out), m_level());
        check_val("full", int'(Full_out), int'(m_level() == 16));
        check_val("empty", int'(Empty_out), int'(m_level() == 0));
        check_val("afull", int'(AlmostFull_out), int'(m_level() >= 12));
        check_val("ovf", int'(Overflow_out), int'(m_ovf));
        check_val("unf", int'(Underflow_out), int'(m_unf));
        check_val("wgray", int'(WrPtrGray_out), exp_gray(m_wr));
        check_val("rgray", int'(RdPtrGray_out), exp_gray(m_rd));
        check_val("wraddr", int'(WrAddr_out), m_wr % 16);
        check_val("rdaddr", int'(RdAddr_out), m_rd % 16);
    endtask

    // One clock cycle: drive, check handshake, advance model, check registered state.
    task automatic step(input bit wr, input bit rd, input bit fl);
        bit   ew;
        bit   er;
        logic [4:0] wg0;
        logic [4:0] rg0;
        @(negedge Clk);
        WrEn_in = wr; RdEn_in = rd; Flush_in = fl;
        #1;
        ew = wr && !fl && (m_level() != 16);
        er = rd && !fl && (m_level() != 0);
        check_val("wrack", int'(WrAck_out), int'(ew));
        check_val("rdack", int'(RdAck_out), int'(er));
        wg0 = WrPtrGray_out;
        rg0 = RdPtrGray_out;
        if (fl) begin
            model_reset();
        end else begin
            if (wr && m_level() == 16) m_ovf = 1'b1;
            if (rd && m_level() == 0)  m_unf = 1'b1;
            if (ew) m_wr++;
            if (er) m_rd++;
        end
        @(posedge Clk);
        #1;
        check_state();
        if (ew) check_val("wgray_1bit", $countones(wg0 ^ WrPtrGray_out), 1);
        if (er) check_val("rgray_1bit", $countones(rg0 ^ RdPtrGray_out), 1);
    endtask

    initial begin
        int guard;
        Clear_in = 1'b1; Flush_in = 1'b0; WrEn_in = 1'b0; RdEn_in = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_state();
        @(negedge Clk);
        Clear_in = 1'b0;

        // Idle after reset
        repeat (5) step(1'b0, 1'b0, 1'b0);

        // Fill to full, checking the literal Gray sequence
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check_val("gray_seq", int'(WrPtrGray_out), gray_tbl[i]);
        end
        check_val("full_lvl", int'(Level_out), 16);

        // Full: simultaneous rd+wr accepts only the read; refill then overflow
        step(1'b1, 1'b1, 1'b0);
        check_val("lvl15", int'(Level_out), 15);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("ovf_sticky", int'(Overflow_out), 1);

        // Random interleaving through several pointer wraps
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
        check_val("wrapped", int'(m_wr >= 40), 1);

        // Drain, underflow, and rd+wr while empty
        guard = 0;
        while (m_level() > 0 && guard < 40) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        check_val("drained", m_level(), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_val("lvl1", int'(Level_out), 1);

        // Level 7 with overflow set, then flush with write requested
        step(1'b0, 1'b0, 1'b1);
        repeat (17) step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b1, 1'b0);
        check_val("lvl7", int'(Level_out), 7);
        step(1'b1, 1'b0, 1'b1);
        check_val("flush_lvl", int'(Level_out), 0);

        // Asynchronous clear mid-burst
        repeat (5) step(1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #2;
        Clear_in = 1'b1;
        #1;
        if (WrAck_out) m_wr++;
        model_reset();
        check_state();
        @(negedge Clk);
        Clear_in = 1'b0;
        WrEn_in  = 1'b0;
        repeat (3) step($urandom_range(0, 1) != 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
